// File: rtl/aire_panel_pkg.sv
// rtl/aire_panel_pkg.sv - status code values and 7-segment glyphs for the air-conditioner panel
package aire_panel_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_HOME  = 2'b01,
      ST_SPEED = 2'b10,
      ST_MENU  = 2'b11
   } st_code_e;

   localparam logic [1:0] SPD_LOW  = 2'b01;
   localparam logic [1:0] SPD_MID  = 2'b10;
   localparam logic [1:0] SPD_HIGH = 2'b11;

   localparam logic [2:0] TMP_R1 = 3'b001;
   localparam logic [2:0] TMP_R2 = 3'b010;
   localparam logic [2:0] TMP_R3 = 3'b011;
   localparam logic [2:0] TMP_R4 = 3'b100;

   localparam logic [2:0] MOD_FRIO     = 3'b001;
   localparam logic [2:0] MOD_FRESCO   = 3'b010;
   localparam logic [2:0] MOD_TEMPLADO = 3'b011;
   localparam logic [2:0] MOD_TROPICAL = 3'b100;

   // Digit slot index equals the anode bit it drives.
   localparam logic [1:0] IDX_MODE  = 2'd0;
   localparam logic [1:0] IDX_TEMP  = 2'd1;
   localparam logic [1:0] IDX_SPEED = 2'd2;
   localparam logic [1:0] IDX_STATE = 2'd3;

   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_H    = 7'b0001001;
   localparam logic [6:0] SEG_S    = 7'b0010010;
   localparam logic [6:0] SEG_T    = 7'b0000111;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   // Speed, temperature range and mode all render 1..4 as the digit itself.
   function automatic logic [6:0] level_glyph(input logic [2:0] code);
      logic [6:0] g;
      case (code)
         3'd1:    g = SEG_1;
         3'd2:    g = SEG_2;
         3'd3:    g = SEG_3;
         3'd4:    g = SEG_4;
         default: g = SEG_DASH;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/aire_glyph_rom.sv
// rtl/aire_glyph_rom.sv - maps a digit slot and the captured status codes to a segment pattern
module aire_glyph_rom
   import aire_panel_pkg::*;
(
   input  logic [1:0] idx,
   input  logic [1:0] st,
   input  logic [1:0] spd,
   input  logic [2:0] tmp,
   input  logic [2:0] mode,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (idx)
         IDX_STATE: begin
            case (st)
               ST_HOME:  seg = SEG_H;
               ST_SPEED: seg = SEG_S;
               ST_MENU:  seg = SEG_T;
               default:  seg = SEG_DASH;
            endcase
         end
         IDX_SPEED: seg = level_glyph({1'b0, spd});
         IDX_TEMP:  seg = level_glyph(tmp);
         default:   seg = level_glyph(mode);
      endcase
   end

endmodule

// File: rtl/aire_panel_display.sv
// rtl/aire_panel_display.sv - 4-digit multiplexed 7-segment readout of the controller status
// with blinking of the field being edited.
module aire_panel_display
   import aire_panel_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] st_code,
   input  logic [1:0] spd_code,
   input  logic [2:0] tmp_code,
   input  logic [2:0] mod_code,
   output logic [6:0] seg,
   output logic [3:0] an
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [1:0]    st_q, st_d;
   logic [1:0]    spd_q, spd_d;
   logic [2:0]    tmp_q, tmp_d;
   logic [2:0]    mod_q, mod_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [1:0]    idx_q, idx_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          dark_q, dark_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;

   logic          tick;
   logic          wrap;
   logic          in_blink_field;
   logic [6:0]    glyph;

   // Glyph is looked up for the slot about to be shown, so it lands with the tick.
   aire_glyph_rom u_glyph_rom (
      .idx  (idx_d),
      .st   (st_q),
      .spd  (spd_q),
      .tmp  (tmp_q),
      .mode (mod_q),
      .seg  (glyph)
   );

   always_comb begin
      st_d    = st_code;
      spd_d   = spd_code;
      tmp_d   = tmp_code;
      mod_d   = mod_code;

      tick    = (pre_q == PRE_LAST);
      wrap    = tick && (idx_q == IDX_STATE);
      pre_d   = tick ? '0 : pre_q + 1'b1;
      idx_d   = tick ? idx_q + 2'd1 : idx_q;

      frame_d = frame_q;
      dark_d  = dark_q;
      // Entering a new screen restarts the blink so the edited field is visible immediately.
      if (st_code != st_q) begin
         frame_d = '0;
         dark_d  = 1'b0;
      end else if (wrap) begin
         if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            dark_d  = ~dark_q;
         end else begin
            frame_d = frame_q + 1'b1;
         end
      end

      in_blink_field = ((st_q == ST_SPEED) && (idx_d == IDX_SPEED)) ||
                       ((st_q == ST_MENU) && ((idx_d == IDX_TEMP) || (idx_d == IDX_MODE)));

      an_d  = an_q;
      seg_d = seg_q;
      if (tick) begin
         if (st_q == ST_OFF) begin
            an_d  = 4'b1111;
            seg_d = SEG_OFF;
         end else begin
            seg_d = glyph;
            an_d  = (dark_d && in_blink_field) ? 4'b1111 : ~(4'b0001 << idx_d);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st_q    <= '0;
         spd_q   <= '0;
         tmp_q   <= '0;
         mod_q   <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
         frame_q <= '0;
         dark_q  <= 1'b0;
         an_q    <= 4'b1111;
         seg_q   <= SEG_OFF;
      end else begin
         st_q    <= st_d;
         spd_q   <= spd_d;
         tmp_q   <= tmp_d;
         mod_q   <= mod_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         dark_q  <= dark_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;

endmodule
